// File: rtl/fetch_issue_unit_pkg.sv
// Shared widths, fetch-block slot layout and the buffered instruction record
// for the fetch-to-decode issue path.
package fetch_issue_unit_pkg;

  localparam int addressWidth            = 64;
  localparam int instructionWidth        = 32;
  localparam int PidSize                 = 20;
  localparam int TidSize                 = 16;
  localparam int instructionCounterWidth = 64;
  localparam int defaultFifoDepth        = 8;
  localparam int fetchBlockWidth         = 2 * instructionWidth;

  typedef struct packed {
    logic [instructionWidth-1:0] instruction;
    logic [addressWidth-1:0]     address;
    logic                        is64Bit;
    logic [PidSize-1:0]          pid;
    logic [TidSize-1:0]          tid;
  } issueEntry_t;

  // Slot numbering is big-endian: slot0 occupies the most significant word.
  function automatic logic [instructionWidth-1:0] slotWord(
    input logic [fetchBlockWidth-1:0] block,
    input logic                       slot
  );
    return slot ? block[instructionWidth-1:0]
                : block[fetchBlockWidth-1:instructionWidth];
  endfunction

endpackage

// File: rtl/fetch_issue_unit_fifo.sv
// Dual-push / single-pop instruction FIFO with flush and a registered
// almost-full flag (fewer than two free entries after this cycle's update).
module issue_fifo
  import fetch_issue_unit_pkg::*;
#(
  parameter int depth = defaultFifoDepth
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic [1:0]  pushCount,
  input  issueEntry_t pushEntry0,
  input  issueEntry_t pushEntry1,
  input  logic        pop,
  output issueEntry_t headEntry,
  output logic        empty,
  output logic        almostFull
);

  localparam int ptrW = $clog2(depth);
  localparam int cntW = ptrW + 1;

  issueEntry_t            mem [depth];
  logic [ptrW-1:0]        head;
  logic [ptrW-1:0]        tail;
  logic [cntW-1:0]        count;
  logic [cntW-1:0]        countNext;

  assign countNext = count + cntW'(pushCount) - cntW'(pop);
  assign empty     = (count == '0);
  assign headEntry = mem[head];

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      almostFull <= 1'b1;
    end else if (flush_i) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      almostFull <= 1'b0;
    end else begin
      head       <= head + ptrW'(pop);
      tail       <= tail + ptrW'(pushCount);
      count      <= countNext;
      almostFull <= (countNext > cntW'(depth - 2));
    end
  end

  // Storage is pure data; validity is tracked by the pointers alone.
  always_ff @(posedge clock_i) begin
    if (pushCount != 2'd0) mem[tail] <= pushEntry0;
    if (pushCount == 2'd2) mem[tail + ptrW'(1)] <= pushEntry1;
  end

endmodule

// File: rtl/fetch_issue_unit.sv
// Transmitter side of the decode instruction interface: expands fetch blocks,
// buffers them, stamps major IDs and holds the presented instruction on stall.
module fetch_issue_unit
  import fetch_issue_unit_pkg::*;
#(
  parameter int fifoDepth = defaultFifoDepth
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               fetchValid_i,
  output logic                               fetchReady_o,
  input  logic [fetchBlockWidth-1:0]         fetchBlock_i,
  input  logic [1:0]                         fetchSlotValid_i,
  input  logic [addressWidth-1:0]            fetchAddress_i,
  input  logic                               fetchIs64Bit_i,
  input  logic [PidSize-1:0]                 fetchPid_i,
  input  logic [TidSize-1:0]                 fetchTid_i,
  input  logic                               stall_i,
  output logic                               enable_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o
);

  logic [1:0]                         acceptedSlots;
  logic [1:0]                         pushCount;
  issueEntry_t                        slot0Entry;
  issueEntry_t                        slot1Entry;
  issueEntry_t                        pushEntry0;
  issueEntry_t                        headEntry;
  logic                               fifoEmpty;
  logic                               fifoAlmostFull;
  logic                               pop;
  logic [instructionCounterWidth-1:0] majIdCount;

  // A lone slot1 is compacted into the first push lane so the FIFO stays dense.
  always_comb begin
    acceptedSlots = (fetchValid_i && fetchReady_o && !flush_i) ? fetchSlotValid_i : 2'b00;
    pushCount     = {1'b0, acceptedSlots[0]} + {1'b0, acceptedSlots[1]};
    slot0Entry    = '{instruction: slotWord(fetchBlock_i, 1'b0),
                      address:     fetchAddress_i,
                      is64Bit:     fetchIs64Bit_i,
                      pid:         fetchPid_i,
                      tid:         fetchTid_i};
    slot1Entry    = '{instruction: slotWord(fetchBlock_i, 1'b1),
                      address:     fetchAddress_i + addressWidth'(4),
                      is64Bit:     fetchIs64Bit_i,
                      pid:         fetchPid_i,
                      tid:         fetchTid_i};
    pushEntry0    = acceptedSlots[0] ? slot0Entry : slot1Entry;
  end

  issue_fifo #(.depth(fifoDepth)) fifo (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .flush_i    (flush_i),
    .pushCount  (pushCount),
    .pushEntry0 (pushEntry0),
    .pushEntry1 (slot1Entry),
    .pop        (pop),
    .headEntry  (headEntry),
    .empty      (fifoEmpty),
    .almostFull (fifoAlmostFull)
  );

  assign fetchReady_o = !fifoAlmostFull;
  assign pop          = !fifoEmpty && !flush_i && (!enable_o || !stall_i);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      enable_o             <= 1'b0;
      instruction_o        <= '0;
      instructionAddress_o <= '0;
      is64Bit_o            <= 1'b0;
      instructionPid_o     <= '0;
      instructionTid_o     <= '0;
      instructionMajId_o   <= '0;
    end else if (flush_i) begin
      enable_o <= 1'b0;
    end else if (pop) begin
      enable_o             <= 1'b1;
      instruction_o        <= headEntry.instruction;
      instructionAddress_o <= headEntry.address;
      is64Bit_o            <= headEntry.is64Bit;
      instructionPid_o     <= headEntry.pid;
      instructionTid_o     <= headEntry.tid;
      instructionMajId_o   <= majIdCount;
    end else if (!stall_i) begin
      enable_o <= 1'b0;
    end
  end

  // Never rewound on flush so IDs stay unique across redirects.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i)  majIdCount <= '0;
    else if (pop)  majIdCount <= majIdCount + instructionCounterWidth'(1);
  end

endmodule
